// File: rtl/regfile_multiport.sv
// Multi-port register file with two write ports (port 1 wins), optional write-to-read bypass,
// a per-register busy scoreboard for issue-stage reservations and an optional hardwired zero register.
module regfile_multiport #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned NUM_READ   = 2,
    parameter int unsigned ZERO_REG   = 1,
    parameter int unsigned BYPASS     = 1
) (
    input  logic                           clock,
    input  logic                           ctrl_reset,
    input  logic                           ctrl_writeEnable0,
    input  logic [ADDR_WIDTH-1:0]          ctrl_writeReg0,
    input  logic [DATA_WIDTH-1:0]          data_writeReg0,
    input  logic                           ctrl_writeEnable1,
    input  logic [ADDR_WIDTH-1:0]          ctrl_writeReg1,
    input  logic [DATA_WIDTH-1:0]          data_writeReg1,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] ctrl_readReg,
    output logic [NUM_READ*DATA_WIDTH-1:0] data_readReg,
    output logic [NUM_READ-1:0]            busy_readReg,
    input  logic                           ctrl_reserveEnable,
    input  logic [ADDR_WIDTH-1:0]          ctrl_reserveReg,
    output logic                           reserve_stall
);

    localparam int unsigned NumRegs  = 1 << ADDR_WIDTH;
    localparam bit          ZeroEn   = (ZERO_REG != 0);
    localparam bit          BypassEn = (BYPASS != 0);

    logic [NumRegs-1:0][DATA_WIDTH-1:0]  regs_q, regs_d;
    logic [NumRegs-1:0]                  busy_q, busy_d;
    logic [NUM_READ-1:0][ADDR_WIDTH-1:0] rd_idx;
    logic [NUM_READ-1:0][DATA_WIDTH-1:0] rd_data;
    logic [NUM_READ-1:0]                 rd_busy;
    logic                                we0, we1;
    logic                                res_write_hit;
    logic                                reserve_ok;

    assign rd_idx       = ctrl_readReg;
    assign data_readReg = rd_data;
    assign busy_readReg = rd_busy;

    // Qualify requests with reset so nothing is forwarded while the file is held cleared.
    always_comb begin
        we0 = ctrl_reset && ctrl_writeEnable0 && !(ZeroEn && ctrl_writeReg0 == '0);
        we1 = ctrl_reset && ctrl_writeEnable1 && !(ZeroEn && ctrl_writeReg1 == '0);
        res_write_hit = (we0 && ctrl_writeReg0 == ctrl_reserveReg) ||
                        (we1 && ctrl_writeReg1 == ctrl_reserveReg);
        reserve_stall = ctrl_reset && ctrl_reserveEnable && busy_q[ctrl_reserveReg] &&
                        !(BypassEn && res_write_hit);
        reserve_ok    = ctrl_reset && ctrl_reserveEnable && !reserve_stall &&
                        !(ZeroEn && ctrl_reserveReg == '0);
    end

    // Reservation is applied after the write clear so a new producer keeps the register busy.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (we0) begin
            regs_d[ctrl_writeReg0] = data_writeReg0;
            busy_d[ctrl_writeReg0] = 1'b0;
        end
        if (we1) begin
            regs_d[ctrl_writeReg1] = data_writeReg1;
            busy_d[ctrl_writeReg1] = 1'b0;
        end
        if (reserve_ok) begin
            busy_d[ctrl_reserveReg] = 1'b1;
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int k = 0; k < int'(NUM_READ); k++) begin
            rd_data[k] = regs_q[rd_idx[k]];
            rd_busy[k] = busy_q[rd_idx[k]];
            if (BypassEn) begin
                if (we1 && ctrl_writeReg1 == rd_idx[k]) begin
                    rd_data[k] = data_writeReg1;
                    rd_busy[k] = 1'b0;
                end else if (we0 && ctrl_writeReg0 == rd_idx[k]) begin
                    rd_data[k] = data_writeReg0;
                    rd_busy[k] = 1'b0;
                end
            end
            if (ZeroEn && rd_idx[k] == '0) begin
                rd_data[k] = '0;
                rd_busy[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            regs_q <= '0;
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

endmodule
